alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width; power of two, >= 4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port valid_in  input  1  operation request; accepted on a rising edge where valid_in=1 and ready_out=1.
REQ-005 SHALL have port ready_out  output  1  high when a request can be accepted.
REQ-006 SHALL have port unit_sel_in  input  3  unit select: 000 add/sub, 001 pass src, 010 shift, 011 multiply, 100 OR, 101 XOR, 110 AND, 111 pass acc.
REQ-007 SHALL have port op_sel_in  input  1  add/sub: 1=subtract; shift: 1=logical right, 0=logical left.
REQ-008 SHALL have port mul_seg_sel_in  input  1  multiply: 0=low WIDTH bits, 1=high WIDTH bits of product.
REQ-009 SHALL have ports acc_in, src_in  input  WIDTH  operands.
REQ-010 SHALL have port res_out  output  WIDTH  registered result, held until next result.
REQ-011 SHALL have port valid_out  output  1  one-cycle pulse, new result on res_out.
REQ-012 SHALL have port carry_out  output  1  registered carry flag.
REQ-013 SHALL have port zero_out  output  1  combinational res_out==0.

Function
REQ-014 SHALL implement states IDLE and MUL; ready_out=1 in IDLE only.
REQ-015 In IDLE, an accepted non-multiply request SHALL register res_out/carry_out at the accept edge; valid_out=1 in the following cycle; state stays IDLE (back-to-back issue, one per cycle).
REQ-016 Add: res=acc+src, carry_out=carry-out of bit WIDTH-1; subtract: res=acc+~src+1, carry_out=1 means no borrow.
REQ-017 Shift: amount = src_in[log2(WIDTH)-1:0], zero fill, carry_out=0.
REQ-018 Logic and pass units SHALL set carry_out=0.
REQ-019 Accepted multiply SHALL capture acc, src, mul_seg_sel, clear a 2*WIDTH accumulator, enter MUL.
REQ-020 MUL SHALL perform unsigned shift-add, one multiplier bit per cycle, exactly WIDTH cycles via an iteration counter.
REQ-021 On the WIDTH-th MUL edge SHALL write the selected product half to res_out, carry_out=0, return to IDLE; valid_out=1 the next cycle (accept-to-valid latency WIDTH+1 edges).
REQ-022 valid_in SHALL be ignored while ready_out=0; no request queued.
REQ-023 valid_out SHALL be 0 in every cycle not following a result write.
REQ-024 Counter SHALL wrap to 0 on completion; no overrun into a second multiply.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force state IDLE, counter 0, res_out 0, carry_out 0, valid_out 0 (hence zero_out=1, ready_out=1).
REQ-026 Reset during MUL SHALL abort the multiply; no valid_out pulse for it.
REQ-027 A request with valid_in=1 on a reset edge SHALL NOT be accepted.

Configuration
REQ-028 Macro ALU_MC_MUL_EN defined: multiply unit and MUL state present per REQ-019..021.
REQ-029 ALU_MC_MUL_EN undefined: no multiplier logic; unit 011 = pass src_in, single-cycle per REQ-015; ready_out constant 1 outside reset; mul_seg_sel_in ignored.

Verification (WIDTH=8)
REQ-030 Add acc=0xFF src=0x01 -> next cycle valid_out=1, res_out=0x00, carry_out=1, zero_out=1.
REQ-031 Sub acc=0x05 src=0x07 -> res_out=0xFE, carry_out=0; then shift right acc=0x80 src=0x03 back-to-back -> res_out=0x10 next cycle.
REQ-032 MUL_EN, multiply acc=0xFF src=0xFF seg=1 -> ready_out=0 for 8 cycles, valid_out 9 edges after accept, res_out=0xFE; seg=0 -> 0x01.
REQ-033 MUL_EN, valid_in held high with XOR request during MUL -> not accepted until ready_out=1; exactly one valid_out per accepted request.
REQ-034 MUL_EN, rst_n low for one edge at MUL cycle 4 -> no valid_out, res_out=0x00, ready_out=1 next cycle.
REQ-035 MUL_EN undefined, unit 011 src=0x5A -> next cycle res_out=0x5A, ready_out never low.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: single-cycle ALU with optional shift-add multiplier (define ALU_MC_MUL_EN to include it)
module alu_mc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [2:0]       unit_sel_in,
    input  logic             op_sel_in,
    input  logic             mul_seg_sel_in,
    input  logic [WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0] src_in,
    output logic [WIDTH-1:0] res_out,
    output logic             valid_out,
    output logic             carry_out,
    output logic             zero_out
);
    localparam int SW = $clog2(WIDTH);

    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_res;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    assign accept   = valid_in & ready_out;
    assign zero_out = res_out == '0;

    // single-cycle units; subtract is acc + ~src + 1 so the carry means "no borrow"
    always_comb begin
        sum     = {1'b0, acc_in} + {1'b0, op_sel_in ? ~src_in : src_in} + (WIDTH + 1)'(op_sel_in);
        alu_res = src_in;
        alu_c   = 1'b0;
        case (unit_sel_in)
            3'b000: {alu_c, alu_res} = sum;
            3'b010: alu_res = op_sel_in ? acc_in >> src_in[SW-1:0] : acc_in << src_in[SW-1:0];
            3'b100: alu_res = acc_in | src_in;
            3'b101: alu_res = acc_in ^ src_in;
            3'b110: alu_res = acc_in & src_in;
            3'b111: alu_res = acc_in;
            default: alu_res = src_in;
        endcase
    end

`ifdef ALU_MC_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic               seg;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_nx;
    logic [SW-1:0]      cnt;

    assign mul_start = accept & (unit_sel_in == 3'b011);
    assign mul_done  = (state == MUL) & (cnt == SW'(WIDTH - 1));
    assign prod_nx   = prod + (mplier[cnt] ? {{WIDTH{1'b0}}, mcand} << cnt : '0);
    assign mul_res   = seg ? prod_nx[2*WIDTH-1:WIDTH] : prod_nx[WIDTH-1:0];

    // state register
    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nx;
    end

    // requests are only taken in IDLE; the multiply leaves after its last bit
    always_comb begin
        state_nx  = state;
        ready_out = state == IDLE;
        case (state)
            IDLE: state_nx = mul_start ? MUL : IDLE;
            MUL:  state_nx = mul_done ? IDLE : MUL;
            default: state_nx = IDLE;
        endcase
    end

    // shift-add: one multiplier bit per cycle, counter wraps back to 0 on the last bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt  <= '0;
            prod <= '0;
        end else if (mul_start) begin
            mcand  <= acc_in;
            mplier <= src_in;
            seg    <= mul_seg_sel_in;
            prod   <= '0;
            cnt    <= '0;
        end else if (state == MUL) begin
            prod <= prod_nx;
            cnt  <= cnt + SW'(1);
        end
    end
`else
    logic unused_seg;

    assign unused_seg = mul_seg_sel_in;
    assign ready_out  = 1'b1;
    assign mul_start  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_res    = '0;
`endif

    // result register: single-cycle ops at accept, multiply on its final bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_out   <= '0;
            carry_out <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= (accept & ~mul_start) | mul_done;
            if (accept && !mul_start) begin
                res_out   <= alu_res;
                carry_out <= alu_c;
            end else if (mul_done) begin
                res_out   <= mul_res;
                carry_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed checks of alu_mc against an arithmetic reference model
module tb_alu_mc;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         valid_in = 1'b0;
    logic         op_sel_in = 1'b0;
    logic         mul_seg_sel_in = 1'b0;
    logic [2:0]   unit_sel_in = '0;
    logic [W-1:0] acc_in = '0;
    logic [W-1:0] src_in = '0;
    logic         ready_out;
    logic         valid_out;
    logic         carry_out;
    logic         zero_out;
    logic [W-1:0] res_out;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [8:0] exp_r = '0;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .valid_in(valid_in),
        .ready_out(ready_out),
        .unit_sel_in(unit_sel_in),
        .op_sel_in(op_sel_in),
        .mul_seg_sel_in(mul_seg_sel_in),
        .acc_in(acc_in),
        .src_in(src_in),
        .res_out(res_out),
        .valid_out(valid_out),
        .carry_out(carry_out),
        .zero_out(zero_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {carry, result} straight from the arithmetic meaning of each unit
    function automatic logic [8:0] model(input logic [2:0] u, input logic op, input logic seg,
                                         input logic [7:0] a, input logic [7:0] b);
        int s;
        case (u)
            3'd0: s = op ? int'(a) + 256 - int'(b) : int'(a) + int'(b);
            3'd1: s = int'(b);
`ifdef ALU_MC_MUL_EN
            3'd3: s = seg ? (int'(a) * int'(b)) / 256 : (int'(a) * int'(b)) % 256;
`else
            3'd3: s = int'(b);
`endif
            3'd2: s = op ? int'(a) / (1 << (int'(b) % 8)) : (int'(a) * (1 << (int'(b) % 8))) % 256;
            3'd4: s = int'(a | b);
            3'd5: s = int'(a ^ b);
            3'd6: s = int'(a & b);
            default: s = int'(a);
        endcase
        return 9'(s);
    endfunction

    task automatic drive(input logic [2:0] u, input logic op, input logic seg,
                         input logic [7:0] a, input logic [7:0] b, input logic v);
        unit_sel_in    = u;
        op_sel_in      = op;
        mul_seg_sel_in = seg;
        acc_in         = a;
        src_in         = b;
        valid_in       = v;
    endtask

    task automatic alu_op(input string tag, input logic [2:0] u, input logic op,
                          input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        drive(u, op, 1'b0, a, b, 1'b1);
        exp_r = model(u, op, 1'b0, a, b);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        check({tag, "_valid"}, valid_out, 1);
        check({tag, "_res"}, res_out, exp_r[7:0]);
        check({tag, "_carry"}, carry_out, exp_r[8]);
        check({tag, "_zero"}, zero_out, exp_r[7:0] == 8'h00);
    endtask

`ifdef ALU_MC_MUL_EN
    task automatic mul_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic seg);
        int lat = 0;
        int rl = 0;
        @(negedge clk);
        drive(3'd3, 1'b0, seg, a, b, 1'b1);
        exp_r = model(3'd3, 1'b0, seg, a, b);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        while (!valid_out && lat < 20) begin
            if (!ready_out) rl++;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, lat, W);
        check({tag, "_ready_low"}, rl, W);
        check({tag, "_res"}, res_out, exp_r[7:0]);
        check({tag, "_carry"}, carry_out, 0);
        @(posedge clk);
        #1;
        check({tag, "_single_pulse"}, valid_out, 0);
    endtask
`endif

    initial begin
        logic [2:0] u;
        logic       op;
        logic       seg;
        logic       v;
        logic [7:0] a;
        logic [7:0] b;
        int         pulses;

        repeat (2) @(posedge clk);
        #1;
        check("rst_res", res_out, 0);
        check("rst_carry", carry_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_zero", zero_out, 1);
        check("rst_ready", ready_out, 1);
        rst_n = 1'b1;

        alu_op("add_wrap", 3'd0, 1'b0, 8'hFF, 8'h01);
        alu_op("sub_borrow", 3'd0, 1'b1, 8'h05, 8'h07);
        alu_op("shr_b2b", 3'd2, 1'b1, 8'h80, 8'h03);
        alu_op("shl", 3'd2, 1'b0, 8'h81, 8'h0F);
        alu_op("sub_eq", 3'd0, 1'b1, 8'h33, 8'h33);
        alu_op("pass_acc", 3'd7, 1'b0, 8'hA5, 8'h00);
`ifndef ALU_MC_MUL_EN
        alu_op("unit3_pass", 3'd3, 1'b0, 8'h11, 8'h5A);
`else
        mul_op("mul_hi", 8'hFF, 8'hFF, 1'b1);
        mul_op("mul_lo", 8'hFF, 8'hFF, 1'b0);
        for (int i = 0; i < 6; i++) mul_op("mul_rnd", 8'($urandom), 8'($urandom), 1'($urandom));

        // XOR request held high through a multiply: exactly one pulse per accepted request
        @(negedge clk);
        drive(3'd3, 1'b0, 1'b0, 8'h0D, 8'h0B, 1'b1);
        @(posedge clk);
        #1;
        drive(3'd5, 1'b0, 1'b0, 8'h3C, 8'h0F, 1'b1);
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            v = ready_out & valid_in;
            @(posedge clk);
            #1;
            if (v) valid_in = 1'b0;
            if (valid_out) begin
                pulses++;
                check(pulses == 1 ? "hold_mul_res" : "hold_xor_res", res_out, pulses == 1 ? 8'h8F : 8'h33);
            end
        end
        check("hold_pulses", pulses, 2);
        exp_r = 9'h033;

        // reset at the fourth multiply cycle aborts it silently
        @(negedge clk);
        drive(3'd3, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_res", res_out, 0);
        check("abort_valid", valid_out, 0);
        check("abort_ready", ready_out, 1);
        check("abort_zero", zero_out, 1);
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (valid_out) pulses++;
        end
        check("abort_no_pulse", pulses, 0);
        exp_r = '0;
`endif

        // a request coinciding with a reset edge is dropped
        alu_op("pre_rst", 3'd6, 1'b0, 8'hF0, 8'h3C);
        @(negedge clk);
        rst_n = 1'b0;
        drive(3'd0, 1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst_n = 1'b1;
        check("rst_req_valid", valid_out, 0);
        check("rst_req_res", res_out, 0);
        @(posedge clk);
        #1;
        check("rst_req_after", valid_out, 0);
        exp_r = '0;

        // random single-cycle traffic, one decision per cycle
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            u = 3'($urandom_range(0, 7));
`ifdef ALU_MC_MUL_EN
            if (u == 3'd3) u = 3'd5;
`endif
            op  = 1'($urandom);
            seg = 1'($urandom);
            a   = 8'($urandom);
            b   = 8'($urandom);
            v   = $urandom_range(0, 3) != 0;
            drive(u, op, seg, a, b, v);
            if (v) exp_r = model(u, op, seg, a, b);
            @(posedge clk);
            #1;
            check("rnd_valid", valid_out, v);
            check("rnd_res", res_out, exp_r[7:0]);
            check("rnd_carry", carry_out, exp_r[8]);
            check("rnd_zero", zero_out, exp_r[7:0] == 8'h00);
`ifndef ALU_MC_MUL_EN
            check("rnd_ready", ready_out, 1);
`endif
        end
        valid_in = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
